// File: rtl/disp_num_writer.sv
// ============================================================================
// Module   : disp_num_writer
// Brief    : Formats a 16-bit value as a 6-character decimal/hex field and
//            writes it into the character display RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_num_writer #(
    parameter int COL_W   = 6,
    parameter int ROW_W   = 4,
    parameter int ADDR_W  = 10,
    parameter int FIELD_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       value,
    input  logic              is_signed,
    input  logic              hex_mode,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_Adr,
    output logic [7:0]        ram_Data,
    output logic              write_Ram
);

    localparam logic [3:0] c_last_idx  = 4'(FIELD_W - 1);
    localparam logic [3:0] c_last_conv = 4'd15;
    localparam logic [7:0] c_space     = 8'h20;
    localparam logic [7:0] c_minus     = 8'h2D;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CONV  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state, w_state;
    logic [15:0]        r_mag, w_mag;
    logic [19:0]        r_bcd, w_bcd;
    logic               r_neg, w_neg;
    logic               r_hex, w_hex;
    logic               r_signed, w_signed;
    logic [ROW_W-1:0]   r_row, w_row;
    logic [COL_W-1:0]   r_col, w_col;
    logic [3:0]         r_cnt, w_cnt;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_we, w_we;
    logic [ADDR_W-1:0]  r_adr, w_adr;
    logic [7:0]         r_data, w_data;

    logic [19:0]        w_adj;
    logic [23:0]        w_bcd_ext;
    logic [23:0]        w_mag_ext;
    logic [2:0]         w_sel;
    logic [3:0]         w_digit;
    logic [3:0]         w_hex_nib;
    logic [3:0]         w_first;
    logic [7:0]         w_char;

    // Character generation for the current field position r_cnt.
    always_comb begin
        w_bcd_ext = {4'h0, r_bcd};
        w_mag_ext = {8'h00, r_mag};
        w_sel     = 3'd5 - r_cnt[2:0];
        w_digit   = w_bcd_ext[{w_sel, 2'b00} +: 4];
        w_hex_nib = w_mag_ext[{w_sel, 2'b00} +: 4];
        // Position of the leftmost nonzero digit; D0 is always printed.
        w_first = 4'd5;
        for (int k = 5; k >= 1; k--) begin
            if (w_bcd_ext[4*(5-k) +: 4] != 4'h0) begin
                w_first = 4'(k);
            end
        end
        w_char = c_space;
        if (r_hex) begin
            if (r_cnt >= 4'd2) begin
                w_char = (w_hex_nib < 4'd10) ? (8'h30 + {4'h0, w_hex_nib})
                                             : (8'h37 + {4'h0, w_hex_nib});
            end
        end else if (r_cnt >= w_first) begin
            w_char = 8'h30 | {4'h0, w_digit};
        end else if (r_neg && (r_cnt == w_first - 4'd1)) begin
            w_char = c_minus;
        end
    end

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                         : r_bcd[4*k +: 4];
        end
    end

    always_comb begin
        w_state  = r_state;
        w_mag    = r_mag;
        w_bcd    = r_bcd;
        w_neg    = r_neg;
        w_hex    = r_hex;
        w_signed = r_signed;
        w_row    = r_row;
        w_col    = r_col;
        w_cnt    = r_cnt;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_we     = 1'b0;
        w_adr    = r_adr;
        w_data   = r_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mag    = value;
                    w_signed = is_signed;
                    w_hex    = hex_mode;
                    w_row    = row;
                    w_col    = col;
                    w_busy   = 1'b1;
                    w_state  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_neg = r_signed && !r_hex && r_mag[15];
                if (w_neg) begin
                    w_mag = -r_mag;
                end
                w_bcd   = 20'h0;
                w_cnt   = 4'd0;
                w_state = r_hex ? S_WRITE : S_CONV;
            end
            S_CONV: begin
                {w_bcd, w_mag} = {w_adj, r_mag} << 1;
                w_cnt = r_cnt + 4'd1;
                if (r_cnt == c_last_conv) begin
                    w_cnt   = 4'd0;
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_we   = 1'b1;
                w_adr  = {r_row, r_col + COL_W'(r_cnt)};
                w_data = w_char;
                w_cnt  = r_cnt + 4'd1;
                if (r_cnt == c_last_idx) begin
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mag    <= 16'h0;
            r_bcd    <= 20'h0;
            r_neg    <= 1'b0;
            r_hex    <= 1'b0;
            r_signed <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_data   <= c_space;
        end else begin
            r_state  <= w_state;
            r_mag    <= w_mag;
            r_bcd    <= w_bcd;
            r_neg    <= w_neg;
            r_hex    <= w_hex;
            r_signed <= w_signed;
            r_row    <= w_row;
            r_col    <= w_col;
            r_cnt    <= w_cnt;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_we     <= w_we;
            r_adr    <= w_adr;
            r_data   <= w_data;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign write_Ram = r_we;
    assign ram_Adr   = r_adr;
    assign ram_Data  = r_data;

endmodule

`default_nettype wire
